pipelined_tree_adder_sub: RTL
=============================

Name: pipelined_tree_adder_sub

Overview:
- Parametrised, pipelined successor to the combinational full tree adder.
- Computes add or subtract with carry/borrow over a valence-2 Brent-Kung prefix tree, split into N_STAGES register stages.
- Elastic valid/ready handshake with backpressure, so it drops into the datapath between a producer and a stalling consumer.
- Also reports carry, signed overflow, zero and negative flags.

Parameters:
- N_BIT, 32, operand/result width; power of two, 4..64.
- N_STAGES, 2, register stages from input to output; 1..(log2(N_BIT)+1); total latency in cycles.
- REG_INPUTS, 0, 1 = stage 0 registers raw operands before p/g generation; 0 = stage 0 registers the p/g level.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- operand_1  in  N_BIT  first operand.
- operand_2  in  N_BIT  second operand.
- carry_in  in  1  carry (add) or borrow (subtract).
- subtract  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  N_BIT  result.
- carry_out  out  1  carries[N_BIT] of the internal addition (subtract: 1 = no borrow).
- overflow  out  1  signed overflow, carries[N_BIT] ^ carries[N_BIT-1].
- zero  out  1  sum == 0.
- negative  out  1  sum[N_BIT-1].

Behaviour:
- Arithmetic:
  - op2_eff = subtract ? ~operand_2 : operand_2; cin_eff = subtract ? ~carry_in : carry_in.
  - {carry_out, sum} = operand_1 + op2_eff + cin_eff, all modulo 2^N_BIT.
  - Subtract therefore yields operand_1 - operand_2 - carry_in.
- Datapath:
  - p = op1 ^ op2_eff; g = op1 & op2_eff; Brent-Kung up-sweep/down-sweep; sum[i] = p[i] ^ carries[i].
- Stage partitioning:
  - Tree levels are distributed across stages as evenly as possible; any surplus levels go to the later stages.
  - p, mode-independent flags and cin_eff travel with each stage.
  - No combinational path from operand_* to sum.
- Latency: an accepted input appears on out_valid exactly N_STAGES cycles later when out_ready is held 1.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Each stage k has a valid bit v[k]. It advances when the next stage is empty or advancing; the last stage advances on out_ready.
  - in_ready = ~v[0] | advance[0]. This is combinational from out_ready through the stage chain; no registered skid.
  - A bubble inside the pipeline collapses while the output is stalled.
- Stall: while out_valid & ~out_ready:
  - sum and all flags hold stable.
  - No accepted data is lost or duplicated.
  - Up to N_STAGES results are held in flight.
- Throughput: one result per cycle with out_ready = 1.
- Data registers update only on advance. They need no reset; only valid bits are reset.
- Reset:
  - rst = 1 clears every v[k] on the next rising edge.
  - out_valid = 0 and in_ready = 1 from the first cycle after reset.
  - Sum and flags are don't-care while out_valid = 0; the bench must not check them.
  - Mid-operation reset discards all in-flight results, with no output for them.
  - in_valid during the rst cycle is ignored.
- Simultaneous input accept and output pop with the pipeline full: both occur; occupancy is unchanged.
- Wrap-around: the sum wraps modulo 2^N_BIT, flagged by carry_out and overflow; no saturation.

Test Plan:
- Add, N_BIT=32, N_STAGES=2, out_ready=1: 0xFFFFFFFF + 0x00000001, cin=0 -> 2 cycles later:
  - sum 0x00000000, carry_out 1, overflow 0, zero 1.
- Signed overflow add: 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, overflow 1, negative 1, carry_out 0.
- Subtract with borrow: subtract=1, 0x00000005 - 0x00000007, borrow-in 1 -> sum 0xFFFFFFFD, carry_out 0, negative 1.
- Backpressure: stream 8 back-to-back adds (i + 100*i) with out_ready low for cycles 3-6:
  - in_ready falls once N_STAGES results are held.
  - All 8 results emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 2 results in flight -> next cycle out_valid 0, in_ready 1; the flushed results never appear.
- Random sweep over N_BIT ∈ {8,32,64} and N_STAGES ∈ {1, max}: 10k random operands, mode, cin and ready patterns.
  - Compare against a behavioural scoreboard of the arithmetic equations above, including all flags.

Source files
------------

// File: rtl/pipelined_tree_adder_sub.sv
// Pipelined add/subtract over a Brent-Kung prefix tree with carry, overflow, zero and negative flags.
// Latency N_STAGES cycles; out_ready stalls ripple combinationally back to in_ready and bubbles collapse.
module pipelined_tree_adder_sub #(
  parameter int N_BIT      = 32,
  parameter int N_STAGES   = 2,
  parameter bit REG_INPUTS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] operand_1,
  input  logic [N_BIT-1:0] operand_2,
  input  logic             carry_in,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int LG      = $clog2(N_BIT);
  localparam int N_OPS   = 2 * LG;
  localparam int N_SEGS  = REG_INPUTS ? N_STAGES - 1 : N_STAGES;
  localparam int SEG_OFS = REG_INPUTS ? 1 : 0;

  // Before the p/g op: p = operand_1, g = operand_2. Afterwards g[i] holds carries[i+1].
  typedef struct packed {
    logic [N_BIT-1:0] p;
    logic [N_BIT-1:0] g;
    logic [N_BIT-1:0] pp;
    logic             ci;
    logic             sub;
  } st_t;

  // Position (ops completed) captured by stage k; surplus ops land on the later stages.
  function automatic int reg_pos(input int k);
    int pos;
    int base;
    int extra;
    pos = 0;
    if (N_SEGS > 0) begin
      base  = N_OPS / N_SEGS;
      extra = N_OPS % N_SEGS;
      for (int s = 0; s <= k - SEG_OFS; s++) begin
        pos += base + ((s >= N_SEGS - extra) ? 1 : 0);
      end
    end
    return pos;
  endfunction

  function automatic int stage_at(input int pos);
    int hit;
    hit = -1;
    for (int k = 0; k < N_STAGES; k++) begin
      if (reg_pos(k) == pos) hit = k;
    end
    return hit;
  endfunction

  logic [N_STAGES-1:0] r_vld;
  logic [N_STAGES-1:0] w_adv;
  logic [N_STAGES-1:0] w_load;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_ctl
    if (k == N_STAGES - 1) begin : g_last
      assign w_adv[k] = out_ready;
    end else begin : g_mid
      assign w_adv[k] = out_ready | ~(&r_vld[N_STAGES-1:k+1]);
    end
    if (k == 0) begin : g_first
      assign w_load[k] = in_valid & in_ready;
    end else begin : g_next
      assign w_load[k] = r_vld[k-1] & w_adv[k-1];
    end
  end

  assign in_ready  = ~r_vld[0] | w_adv[0];
  assign out_valid = r_vld[N_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) r_vld <= '0;
    else     r_vld <= w_load | (r_vld & ~w_adv);
  end

  for (genvar j = 0; j <= N_OPS; j++) begin : g_pos
    localparam int K = stage_at(j);
    st_t w_y;
    st_t w_z;

    if (j == 0) begin : g_src
      assign w_y = {operand_1, operand_2, {N_BIT{1'b0}}, carry_in, subtract};
    end else if (j == 1) begin : g_pg
      st_t              w_src;
      logic [N_BIT-1:0] w_b;
      logic [N_BIT-1:0] w_hp;
      logic [N_BIT-1:0] w_hg;
      logic             w_c;
      assign w_src  = g_pos[j-1].w_z;
      assign w_b    = w_src.sub ? ~w_src.g : w_src.g;
      assign w_c    = w_src.sub ^ w_src.ci;
      assign w_hp   = w_src.p ^ w_b;
      assign w_hg   = w_src.p & w_b;
      // Folding the effective carry-in into bit 0 makes every prefix G a carry.
      assign w_y.p   = w_hp;
      assign w_y.pp  = w_hp;
      assign w_y.g   = {w_hg[N_BIT-1:1], w_hg[0] | (w_hp[0] & w_c)};
      assign w_y.ci  = w_c;
      assign w_y.sub = 1'b0;
    end else begin : g_lvl
      localparam bit UP   = (j - 1 <= LG);
      localparam int SPAN = UP ? (1 << (j - 2)) : (1 << (N_OPS - j));
      st_t w_src;
      assign w_src   = g_pos[j-1].w_z;
      assign w_y.p   = w_src.p;
      assign w_y.ci  = w_src.ci;
      assign w_y.sub = w_src.sub;
      for (genvar i = 0; i < N_BIT; i++) begin : g_bit
        if (UP ? ((i % (2 * SPAN)) == 2 * SPAN - 1)
               : (((i % (2 * SPAN)) == SPAN - 1) && (i >= 2 * SPAN))) begin : g_node
          assign w_y.g[i]  = w_src.g[i] | (w_src.pp[i] & w_src.g[i-SPAN]);
          assign w_y.pp[i] = w_src.pp[i] & w_src.pp[i-SPAN];
        end else begin : g_pass
          assign w_y.g[i]  = w_src.g[i];
          assign w_y.pp[i] = w_src.pp[i];
        end
      end
    end

    if (K >= 0) begin : g_reg
      st_t r_st;
      always_ff @(posedge clk) begin
        if (w_load[K]) r_st <= w_y;
      end
      assign w_z = r_st;
    end else begin : g_wire
      assign w_z = w_y;
    end
  end

  st_t          w_fin;
  logic [N_BIT:0] w_carries;
  logic         w_unused;

  assign w_fin     = g_pos[N_OPS].w_z;
  assign w_carries = {w_fin.g, w_fin.ci};
  assign w_unused  = ^{w_fin.pp, w_fin.sub};

  assign sum       = w_fin.p ^ w_carries[N_BIT-1:0];
  assign carry_out = w_carries[N_BIT];
  assign overflow  = w_carries[N_BIT] ^ w_carries[N_BIT-1];
  assign zero      = ~|sum;
  assign negative  = sum[N_BIT-1];

endmodule
